// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the register-file write-port arbiter signals: pipeline
// writeback (A), long-latency results (B), issue tracking, hazard
// queries and the shared regfile write port.
`timescale 1ns/1ps
interface rf_wb_arbiter_if #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
);
    logic                   a_we;
    logic [RFIDX_WIDTH-1:0] a_wa;
    logic [XLEN-1:0]        a_wd;
    logic                   b_valid;
    logic                   b_ready;
    logic [RFIDX_WIDTH-1:0] b_wa;
    logic [XLEN-1:0]        b_wd;
    logic                   iss_valid;
    logic [RFIDX_WIDTH-1:0] iss_rd;
    logic [RFIDX_WIDTH-1:0] rs1;
    logic [RFIDX_WIDTH-1:0] rs2;
    logic                   busy_rs1;
    logic                   busy_rs2;
    logic                   stall_req;
    logic                   we3;
    logic [RFIDX_WIDTH-1:0] wa3;
    logic [XLEN-1:0]        wd3;

    // Requester / regfile side (pipeline, long-latency units, hazard unit)
    modport master (
        output a_we, a_wa, a_wd, b_valid, b_wa, b_wd, iss_valid, iss_rd, rs1, rs2,
        input  b_ready, busy_rs1, busy_rs2, stall_req, we3, wa3, wd3
    );

    // Arbiter side
    modport slave (
        input  a_we, a_wa, a_wd, b_valid, b_wa, b_wd, iss_valid, iss_rd, rs1, rs2,
        output b_ready, busy_rs1, busy_rs2, stall_req, we3, wa3, wd3
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback (A) has
// priority; long-latency results (B) queue in a small FIFO and drain in
// idle slots. A starving FIFO head raises a registered stall request so
// the pipeline freezes and the queue drains one entry per cycle. A
// pending-destination bitmap tells the hazard unit which registers still
// await a long-latency write.
`timescale 1ns/1ps
module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int RFIDX_WIDTH  = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input logic           clk,
    input logic           rstn,
    rf_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 1 << RFIDX_WIDTH;

    localparam logic [CNT_W-1:0]       CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]       PTR_ONE  = PTR_W'(1);
    localparam logic [STV_W-1:0]       STV_ZERO = STV_W'(0);
    localparam logic [STV_W-1:0]       STV_ONE  = STV_W'(1);
    localparam logic [STV_W-1:0]       STV_MAX  = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0]       STV_SET  = STV_W'(STARVE_LIMIT - 1);
    localparam logic [RFIDX_WIDTH-1:0] IDX_ZERO = RFIDX_WIDTH'(0);

    logic [RFIDX_WIDTH-1:0] fifo_wa_q [FIFO_DEPTH];
    logic [RFIDX_WIDTH-1:0] fifo_wa_d [FIFO_DEPTH];
    logic [XLEN-1:0]        fifo_wd_q [FIFO_DEPTH];
    logic [XLEN-1:0]        fifo_wd_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STV_W-1:0]       starve_q, starve_d;
    logic                   stall_q, stall_d;
    logic [NREG-1:0]        pend_q, pend_d;

    logic                   empty_s, full_s, a_act_s;
    logic                   grant_fifo_s, grant_a_s, push_s, pop_s;
    logic [RFIDX_WIDTH-1:0] head_wa_s;
    logic [XLEN-1:0]        head_wd_s;
    logic                   we3_s;
    logic [RFIDX_WIDTH-1:0] wa3_s;
    logic [XLEN-1:0]        wd3_s;

    // Grant selection and write-port mux; a frozen pipeline yields to the FIFO
    always_comb begin
        empty_s      = (cnt_q == CNT_ZERO);
        full_s       = (cnt_q == CNT_FULL);
        a_act_s      = bus.a_we && (bus.a_wa != IDX_ZERO);
        head_wa_s    = fifo_wa_q[rd_ptr_q];
        head_wd_s    = fifo_wd_q[rd_ptr_q];
        grant_fifo_s = !empty_s && (stall_q || !a_act_s);
        grant_a_s    = a_act_s && !grant_fifo_s;
        // x0 results are acknowledged but never queued
        push_s       = bus.b_valid && !full_s && (bus.b_wa != IDX_ZERO);
        pop_s        = grant_fifo_s;
        we3_s        = 1'b0;
        wa3_s        = IDX_ZERO;
        wd3_s        = XLEN'(0);
        if (grant_fifo_s) begin
            we3_s = 1'b1;
            wa3_s = head_wa_s;
            wd3_s = head_wd_s;
        end else if (grant_a_s) begin
            we3_s = 1'b1;
            wa3_s = bus.a_wa;
            wd3_s = bus.a_wd;
        end else begin
            we3_s = 1'b0;
        end
    end

    assign bus.we3       = we3_s;
    assign bus.wa3       = wa3_s;
    assign bus.wd3       = wd3_s;
    assign bus.b_ready   = !full_s;
    assign bus.stall_req = stall_q;
    assign bus.busy_rs1  = (bus.rs1 != IDX_ZERO) && pend_q[bus.rs1];
    assign bus.busy_rs2  = (bus.rs2 != IDX_ZERO) && pend_q[bus.rs2];

    // Next state for FIFO storage/pointers, starvation tracking and pending bitmap
    always_comb begin
        fifo_wa_d = fifo_wa_q;
        fifo_wd_d = fifo_wd_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        stall_d   = stall_q;
        pend_d    = pend_q;

        if (push_s) begin
            fifo_wa_d[wr_ptr_q] = bus.b_wa;
            fifo_wd_d[wr_ptr_q] = bus.b_wd;
            wr_ptr_d            = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        if (pop_s || empty_s) begin
            starve_d = STV_ZERO;
        end else if (starve_q != STV_MAX) begin
            starve_d = starve_q + STV_ONE;
        end else begin
            starve_d = starve_q;
        end

        // Raise the stall as the counter crosses its limit; drop it once drained
        if (!empty_s && !pop_s && (starve_q == STV_SET)) begin
            stall_d = 1'b1;
        end else if (pop_s && !push_s && (cnt_q == CNT_ONE)) begin
            stall_d = 1'b0;
        end else begin
            stall_d = stall_q;
        end

        // Clear on commit first so a same-cycle issue to that register wins
        if (pop_s) begin
            pend_d[head_wa_s] = 1'b0;
        end else begin
            pend_d[head_wa_s] = pend_q[head_wa_s];
        end
        if (bus.iss_valid && (bus.iss_rd != IDX_ZERO)) begin
            pend_d[bus.iss_rd] = 1'b1;
        end else begin
            pend_d[bus.iss_rd] = pend_d[bus.iss_rd];
        end
    end

    // State registers; reset drops queued results and all pending marks
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_wa_q[i] <= IDX_ZERO;
                fifo_wd_q[i] <= XLEN'(0);
            end
            rd_ptr_q <= PTR_W'(0);
            wr_ptr_q <= PTR_W'(0);
            cnt_q    <= CNT_ZERO;
            starve_q <= STV_ZERO;
            stall_q  <= 1'b0;
            pend_q   <= NREG'(0);
        end else begin
            fifo_wa_q <= fifo_wa_d;
            fifo_wd_q <= fifo_wd_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            pend_q    <= pend_d;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. Expected writes are queued when the
// stimulus is driven (qa for the pipeline, qb for long-latency results in
// FIFO order) and popped when the write port shows the matching grant.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int SRC_NONE = 0;
    localparam int SRC_A    = 1;
    localparam int SRC_B    = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [RW+XLEN-1:0] qa[$];
    logic [RW+XLEN-1:0] qb[$];

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.XLEN(XLEN), .RFIDX_WIDTH(RW)) bus ();

    rf_wb_arbiter #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .FIFO_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.a_we = 1'b0; bus.a_wa = '0; bus.a_wd = '0;
        bus.b_valid = 1'b0; bus.b_wa = '0; bus.b_wd = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
    endtask

    task automatic expect_wr(input string tag, input int src);
        logic [RW+XLEN-1:0] e;
        chk({tag, "_we3"}, 64'(bus.we3), (src != SRC_NONE) ? 64'd1 : 64'd0);
        if (src == SRC_A && qa.size() > 0) begin
            e = qa.pop_front();
            chk({tag, "_wa3"}, 64'(bus.wa3), 64'(e[RW+XLEN-1:XLEN]));
            chk({tag, "_wd3"}, 64'(bus.wd3), 64'(e[XLEN-1:0]));
        end else if (src == SRC_B && qb.size() > 0) begin
            e = qb.pop_front();
            chk({tag, "_wa3"}, 64'(bus.wa3), 64'(e[RW+XLEN-1:XLEN]));
            chk({tag, "_wd3"}, 64'(bus.wd3), 64'(e[XLEN-1:0]));
        end else begin
            e = '0;
        end
    endtask

    // Pipeline writes every cycle while two B results (base, base+1) queue up.
    // Entry 1 lands at edge E0, so stall is visible in cycles 9 and 10.
    task automatic contend(input int n, input logic [RW-1:0] base);
        logic [RW-1:0] awa;
        logic [RW-1:0] bwa;
        bit a_wins;
        bus.rs1 = base;
        bus.rs2 = RW'(int'(base) + 1);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            awa    = RW'(20 + (k % 8));
            bwa    = RW'(int'(base) + k);
            a_wins = !(k == 9 || k == 10);
            bus.a_we = 1'b1; bus.a_wa = awa; bus.a_wd = 32'hA000_0000 + 32'(k);
            if (a_wins) qa.push_back({awa, bus.a_wd});
            bus.b_valid   = (k < 2);
            bus.b_wa      = bwa;
            bus.b_wd      = 32'hB000_0000 + 32'(k);
            bus.iss_valid = (k < 2);
            bus.iss_rd    = bwa;
            if (k < 2) qb.push_back({bwa, bus.b_wd});
            sample();
            expect_wr($sformatf("cont%0d", k), a_wins ? SRC_A : SRC_B);
            chk($sformatf("cont%0d_stall", k), 64'(bus.stall_req), (k == 9 || k == 10) ? 64'd1 : 64'd0);
            chk($sformatf("cont%0d_bready", k), 64'(bus.b_ready), (k >= 2 && k <= 9) ? 64'd0 : 64'd1);
            chk($sformatf("cont%0d_busy1", k), 64'(bus.busy_rs1), (k >= 1 && k <= 9) ? 64'd1 : 64'd0);
            chk($sformatf("cont%0d_busy2", k), 64'(bus.busy_rs2), (k >= 2 && k <= 10) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with traffic on the inputs: nothing may be accepted or written
        idle_inputs();
        bus.b_valid = 1'b1; bus.b_wa = 5'd3; bus.b_wd = 32'h33;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        bus.rs1 = 5'd3; bus.rs2 = 5'd0;
        repeat (2) @(posedge clk);
        sample();
        chk("rst_we3", 64'(bus.we3), 64'd0);
        chk("rst_bready", 64'(bus.b_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy_rs1), 64'd0);
        chk("rst_stall", 64'(bus.stall_req), 64'd0);

        // Release mid-cycle: FIFO still empty until the next posedge accepts
        rstn = 1'b1;
        bus.iss_valid = 1'b0;
        #1;
        chk("rel_we3", 64'(bus.we3), 64'd0);
        qb.push_back({5'd3, 32'h33});
        next_cycle();
        bus.b_valid = 1'b0;
        sample();
        expect_wr("first_b", SRC_B);
        chk("first_b_bready", 64'(bus.b_ready), 64'd1);
        next_cycle();
        sample();
        expect_wr("after_first", SRC_NONE);

        // Port A only, including an x0 write
        next_cycle();
        bus.a_we = 1'b1; bus.a_wa = 5'd5; bus.a_wd = 32'h1234;
        qa.push_back({5'd5, 32'h1234});
        sample();
        expect_wr("a5", SRC_A);
        next_cycle();
        bus.a_wa = 5'd0; bus.a_wd = 32'h5555;
        sample();
        expect_wr("a_x0", SRC_NONE);

        // Port B drain with scoreboard tracking of x7
        next_cycle();
        bus.a_we = 1'b0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1 = 5'd7;
        sample();
        chk("iss7_busy_c0", 64'(bus.busy_rs1), 64'd0);
        next_cycle();
        bus.iss_valid = 1'b0;
        sample();
        chk("iss7_busy_c1", 64'(bus.busy_rs1), 64'd1);
        next_cycle();
        sample();
        chk("iss7_busy_c2", 64'(bus.busy_rs1), 64'd1);
        next_cycle();
        bus.b_valid = 1'b1; bus.b_wa = 5'd7; bus.b_wd = 32'hDEAD;
        qb.push_back({5'd7, 32'hDEAD});
        sample();
        expect_wr("b7_nobypass", SRC_NONE);
        next_cycle();
        bus.b_valid = 1'b0;
        sample();
        expect_wr("b7_commit", SRC_B);
        chk("b7_busy_commit", 64'(bus.busy_rs1), 64'd1);
        next_cycle();
        sample();
        expect_wr("b7_after", SRC_NONE);
        chk("b7_busy_after", 64'(bus.busy_rs1), 64'd0);

        // A B result for x0 is acknowledged and dropped
        next_cycle();
        bus.b_valid = 1'b1; bus.b_wa = 5'd0; bus.b_wd = 32'hBAD0;
        sample();
        chk("b_x0_bready", 64'(bus.b_ready), 64'd1);
        expect_wr("b_x0_push", SRC_NONE);
        next_cycle();
        bus.b_valid = 1'b0;
        sample();
        expect_wr("b_x0_drop", SRC_NONE);

        // Contention: starvation, stall, in-order drain, A resumes
        contend(12, 5'd11);
        next_cycle();
        idle_inputs();
        sample();
        expect_wr("cont_done", SRC_NONE);
        chk("cont_qb_empty", 64'(qb.size()), 64'd0);

        // Scoreboard collision: re-issue x9 in the cycle x9 commits
        next_cycle();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        sample();
        next_cycle();
        bus.iss_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_wa = 5'd9; bus.b_wd = 32'h99;
        qb.push_back({5'd9, 32'h99});
        sample();
        expect_wr("x9_queued", SRC_NONE);
        next_cycle();
        bus.b_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        sample();
        expect_wr("x9_commit", SRC_B);
        next_cycle();
        bus.iss_valid = 1'b0; bus.rs1 = 5'd0; bus.rs2 = 5'd9;
        sample();
        expect_wr("x9_after", SRC_NONE);
        chk("x9_busy_kept", 64'(bus.busy_rs2), 64'd1);
        chk("rs0_busy", 64'(bus.busy_rs1), 64'd0);

        // Async reset while stalled with two entries queued
        contend(10, 5'd13);
        #2;
        rstn = 1'b0;
        idle_inputs();
        #1;
        chk("arst_we3", 64'(bus.we3), 64'd0);
        chk("arst_stall", 64'(bus.stall_req), 64'd0);
        chk("arst_bready", 64'(bus.b_ready), 64'd1);
        chk("arst_busy1", 64'(bus.busy_rs1), 64'd0);
        chk("arst_busy2", 64'(bus.busy_rs2), 64'd0);
        qa.delete();
        qb.delete();
        sample();
        rstn = 1'b1;
        next_cycle();
        sample();
        expect_wr("arst_idle", SRC_NONE);
        chk("arst_idle_stall", 64'(bus.stall_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
